// File: rtl/note_playback_reader.sv
// note_playback_reader
// Walks the recorded note RAM from address 0 upward and presents each code as
// a note held for NOTE_TICKS cycles. Playback ends on END_CODE or after the
// last address. With loop_en high it wraps to address 0 instead.
// Only the read port of the RAM is used here.
//
// Handshake: none. start is a one-cycle request that is honoured only in
// IDLE. stop is a level that aborts playback from any busy state. mem_data
// must be valid combinationally for the presented mem_address.
module note_playback_reader #(
    parameter int          DEPTH      = 17,
    parameter int          ADDR_WIDTH = 8,
    parameter int          NOTE_TICKS = 25000000,
    parameter logic [7:0]  END_CODE   = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [7:0]            mem_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            note_out,
    output logic                  note_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         TICK_LOAD = CW'(NOTE_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [7:0]            note_next;
    logic                  valid_next;
    logic                  done_next;

    // Busy is a pure decode of the state register, so it drops with reset.
    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = mem_address;
        note_next  = note_out;
        valid_next = note_valid;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = FETCH;
                    addr_next  = '0;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end else if (mem_data != END_CODE) begin
                    state_next = PLAY;
                    note_next  = mem_data;
                    valid_next = 1'b1;
                    cnt_next   = TICK_LOAD;
                end else if (loop_en && (mem_address != '0)) begin
                    // Terminator hit with looping: refetch from the top. An
                    // empty memory (terminator at 0) still finishes.
                    addr_next  = '0;
                end else begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end else if (cnt == '0) begin
                    // Dropping valid here gives one low cycle (FETCH) between
                    // consecutive notes as a retrigger edge.
                    valid_next = 1'b0;
                    if (mem_address != LAST_ADDR) begin
                        addr_next  = mem_address + ADDR_WIDTH'(1);
                        state_next = FETCH;
                    end else if (loop_en) begin
                        addr_next  = '0;
                        state_next = FETCH;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // Registered outputs and the note-length counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            mem_address <= '0;
            note_out    <= 8'h00;
            note_valid  <= 1'b0;
            done        <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            mem_address <= addr_next;
            note_out    <= note_next;
            note_valid  <= valid_next;
            done        <= done_next;
        end
    end

endmodule

// File: tb/tb_note_playback_reader.sv
// Directed bench for note_playback_reader with DEPTH=4, NOTE_TICKS=4.
// Cycle 0 is the cycle in which start is held high; cycle k is observed 1 ns
// after the k-th rising edge that follows it.
module tb_note_playback_reader;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [7:0] mem_data;
    logic [7:0] mem_address;
    logic [7:0] note_out;
    logic       note_valid;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:3];
    int vectors;
    int miscompares;
    int addr_over;

    note_playback_reader #(
        .DEPTH      (4),
        .ADDR_WIDTH (8),
        .NOTE_TICKS (4),
        .END_CODE   (8'h00)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .mem_data    (mem_data),
        .mem_address (mem_address),
        .note_out    (note_out),
        .note_valid  (note_valid),
        .busy        (busy),
        .done        (done)
    );

    // Clock and RAM read model.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_data = mem[mem_address[1:0]];

    // Record any presentation of an address beyond the last entry.
    always @(negedge clock) begin
        if (reset_n && (mem_address > 8'd3)) addr_over++;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] m2, input logic [7:0] m3);
        mem[0] = m0;
        mem[1] = m1;
        mem[2] = m2;
        mem[3] = m3;
    endtask

    // Pulse start in cycle 0; on return the bench sits in cycle 1.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full playback of {3C,3E,40,00} without looping, checked every cycle.
    task automatic run_basic(input string pfx);
        logic ev;
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) tick();
            ev = ((c >= 2) && (c <= 5)) || ((c >= 7) && (c <= 10)) || ((c >= 12) && (c <= 15));
            chk($sformatf("%s_valid_c%0d", pfx, c), note_valid, ev);
            chk($sformatf("%s_done_c%0d", pfx, c), done, (c == 17));
            chk($sformatf("%s_busy_c%0d", pfx, c), busy, (c <= 17));
            if ((c == 1) || (c == 6) || (c == 11) || (c == 16))
                chk($sformatf("%s_addr_c%0d", pfx, c), mem_address, (c - 1) / 5);
            if (c == 2)  chk($sformatf("%s_note_c2", pfx), note_out, 8'h3C);
            if (c == 7)  chk($sformatf("%s_note_c7", pfx), note_out, 8'h3E);
            if (c == 12) chk($sformatf("%s_note_c12", pfx), note_out, 8'h40);
            if (c == 18) chk($sformatf("%s_note_hold", pfx), note_out, 8'h40);
        end
    endtask

    // Directed sequence.
    initial begin
        logic ev;
        vectors     = 0;
        miscompares = 0;
        addr_over   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        load_mem(8'h3C, 8'h3E, 8'h40, 8'h00);

        // 1. Reset held with the clock running.
        repeat (3) tick();
        chk("rst_addr",  mem_address, 8'h00);
        chk("rst_note",  note_out,    8'h00);
        chk("rst_valid", note_valid,  1'b0);
        chk("rst_busy",  busy,        1'b0);
        chk("rst_done",  done,        1'b0);
        reset_n = 1'b1;
        tick();

        // start and stop together in IDLE: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("idle_start_stop_busy", busy, 1'b0);
        tick();

        // 2. Terminated playback.
        run_basic("basic");

        // 3. No terminator: all four notes, done at cycle 21.
        load_mem(8'h01, 8'h02, 8'h03, 8'h04);
        pulse_start();
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) tick();
            ev = ((c >= 2) && (c <= 5)) || ((c >= 7) && (c <= 10)) ||
                 ((c >= 12) && (c <= 15)) || ((c >= 17) && (c <= 20));
            chk($sformatf("full_valid_c%0d", c), note_valid, ev);
            chk($sformatf("full_done_c%0d", c), done, (c == 21));
            chk($sformatf("full_busy_c%0d", c), busy, (c <= 21));
            if (c == 16) chk("full_addr_c16", mem_address, 8'h03);
            if (c == 17) chk("full_note_c17", note_out, 8'h04);
        end
        chk("full_addr_bound", addr_over, 0);

        // 4a. Looping with a terminator at address 3.
        load_mem(8'h3C, 8'h3E, 8'h40, 8'h00);
        loop_en = 1'b1;
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) tick();
            chk($sformatf("loop_done_c%0d", c), done, 1'b0);
            if (c == 16) begin
                chk("loop_addr_c16", mem_address, 8'h03);
                chk("loop_valid_c16", note_valid, 1'b0);
            end
            if (c == 17) begin
                chk("loop_addr_c17", mem_address, 8'h00);
                chk("loop_valid_c17", note_valid, 1'b0);
                chk("loop_busy_c17", busy, 1'b1);
            end
            if (c == 18) begin
                chk("loop_valid_c18", note_valid, 1'b1);
                chk("loop_note_c18", note_out, 8'h3C);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("loop_stop_busy", busy, 1'b0);
        tick();

        // 4b. Empty memory with looping: finishes, no hang.
        load_mem(8'h00, 8'h11, 8'h22, 8'h33);
        pulse_start();
        chk("empty_busy_c1", busy, 1'b1);
        chk("empty_done_c1", done, 1'b0);
        tick();
        chk("empty_done_c2", done, 1'b1);
        chk("empty_valid_c2", note_valid, 1'b0);
        tick();
        chk("empty_done_c3", done, 1'b0);
        chk("empty_busy_c3", busy, 1'b0);
        loop_en = 1'b0;
        tick();

        // 5. stop (with start) in the second cycle of the 3E note.
        load_mem(8'h3C, 8'h3E, 8'h40, 8'h00);
        pulse_start();
        repeat (7) tick();
        chk("stop_pre_note", note_out, 8'h3E);
        chk("stop_pre_valid", note_valid, 1'b1);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("stop_valid", note_valid, 1'b0);
        chk("stop_busy", busy, 1'b0);
        chk("stop_done", done, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stop_idle_done_%0d", c), done, 1'b0);
            chk($sformatf("stop_idle_busy_%0d", c), busy, 1'b0);
        end
        pulse_start();
        chk("restart_addr", mem_address, 8'h00);
        chk("restart_busy", busy, 1'b1);
        tick();
        chk("restart_note", note_out, 8'h3C);
        chk("restart_valid", note_valid, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // 6. Asynchronous reset between edges during the 3E note.
        pulse_start();
        repeat (7) tick();
        chk("arst_pre_addr", mem_address, 8'h01);
        chk("arst_pre_valid", note_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", note_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_addr", mem_address, 8'h00);
        chk("arst_note", note_out, 8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_basic("after_rst");

        chk("addr_bound_total", addr_over, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
